// File: rtl/if_prefetch_queue_if.sv
// Instruction-fetch bus bundle: SRAM-like inst port plus the fetch-to-decode handshake.
interface if_prefetch_queue_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic        ds_allowin;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_exc_adel;
    logic [31:0] fs_badvaddr;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
               inst_sram_wstrb, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output fs_to_ds_valid, fs_pc, fs_inst, fs_exc_adel, fs_badvaddr,
        input  ds_allowin
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
               inst_sram_wstrb, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  fs_to_ds_valid, fs_pc, fs_inst, fs_exc_adel, fs_badvaddr,
        output ds_allowin
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Multi-outstanding fetch front end with in-order instruction queue; data reaches decode one cycle after data_ok,
// or in the same cycle with IF_BYPASS_EN. Requests stall when in-flight + queued entries would exceed the queue.
module if_prefetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          QUEUE_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    if_prefetch_queue_if.master bus
);
    localparam int IW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int IPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QW  = $clog2(QUEUE_DEPTH + 1);
    localparam int QPW = $clog2(QUEUE_DEPTH);
    localparam logic [IPW-1:0] IFL_LAST = IPW'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fq_entry_t;

    logic [31:0]    fpc_q, fpc_d;
    logic [IW-1:0]  inflight_q, inflight_d, discard_q, discard_d;
    logic           halt_q, halt_d;
    logic [IPW-1:0] ifl_wr_q, ifl_wr_d, ifl_rd_q, ifl_rd_d;
    logic [QW-1:0]  qcount_q, qcount_d;
    logic [QPW-1:0] qhead_q, qhead_d, qtail_q, qtail_d;
    logic [31:0]    ifl_pc_q [MAX_OUTSTANDING];
    fq_entry_t      queue_q  [QUEUE_DEPTH];

    logic [31:0] occ;
    logic        fetch_ok, req, adel_enq, push, pop, keep, bypass, enq, deq, q_nonempty;
    fq_entry_t   resp_entry, enq_entry, out_entry;

    function automatic logic [IPW-1:0] ifl_inc(input logic [IPW-1:0] p);
        return (p == IFL_LAST) ? '0 : p + IPW'(1);
    endfunction

    // Responses already owed to discard do not occupy queue space.
    assign occ        = 32'(inflight_q) - 32'(discard_q) + 32'(qcount_q);
    assign fetch_ok   = !reset && !redirect_valid && !halt_q && (occ < 32'(QUEUE_DEPTH));
    assign req        = fetch_ok && (fpc_q[1:0] == 2'b00) && (32'(inflight_q) < 32'(MAX_OUTSTANDING));
    assign adel_enq   = fetch_ok && (fpc_q[1:0] != 2'b00) && (inflight_q == discard_q);
    assign push       = req && bus.inst_sram_addr_ok;
    assign pop        = bus.inst_sram_data_ok;
    assign keep       = pop && (discard_q == '0);
    assign q_nonempty = (qcount_q != '0);
    assign resp_entry = '{pc: ifl_pc_q[ifl_rd_q], inst: bus.inst_sram_rdata, adel: 1'b0};

`ifdef IF_BYPASS_EN
    assign bypass = !reset && !q_nonempty && keep && bus.ds_allowin;
`else
    assign bypass = 1'b0;
`endif

    assign enq       = !redirect_valid && (adel_enq || (keep && !bypass));
    assign enq_entry = adel_enq ? '{pc: fpc_q, inst: 32'h0, adel: 1'b1} : resp_entry;
    assign deq       = !reset && q_nonempty && bus.ds_allowin;
    assign out_entry = q_nonempty ? queue_q[qhead_q] : resp_entry;

    assign bus.inst_sram_req   = req;
    assign bus.inst_sram_wr    = 1'b0;
    assign bus.inst_sram_size  = 2'h2;
    assign bus.inst_sram_addr  = fpc_q;
    assign bus.inst_sram_wstrb = 4'h0;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.fs_to_ds_valid  = !reset && (q_nonempty || bypass);
    assign bus.fs_pc           = out_entry.pc;
    assign bus.fs_inst         = out_entry.inst;
    assign bus.fs_exc_adel     = out_entry.adel;
    assign bus.fs_badvaddr     = out_entry.adel ? out_entry.pc : 32'h0;

    always_comb begin
        ifl_wr_d   = push ? ifl_inc(ifl_wr_q) : ifl_wr_q;
        ifl_rd_d   = pop  ? ifl_inc(ifl_rd_q) : ifl_rd_q;
        inflight_d = inflight_q + IW'(push) - IW'(pop);
        fpc_d      = push ? fpc_q + 32'd4 : fpc_q;
        halt_d     = halt_q || adel_enq;
        discard_d  = (pop && discard_q != '0) ? discard_q - IW'(1) : discard_q;
        qtail_d    = enq ? qtail_q + QPW'(1) : qtail_q;
        qhead_d    = deq ? qhead_q + QPW'(1) : qhead_q;
        qcount_d   = qcount_q + QW'(enq) - QW'(deq);
        if (redirect_valid) begin
            // Everything still in flight (minus the one returning now) is stale.
            fpc_d     = redirect_pc;
            halt_d    = 1'b0;
            discard_d = inflight_q - IW'(pop);
            qtail_d   = '0;
            qhead_d   = '0;
            qcount_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q      <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            halt_q     <= 1'b0;
            ifl_wr_q   <= '0;
            ifl_rd_q   <= '0;
            qcount_q   <= '0;
            qhead_q    <= '0;
            qtail_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            halt_q     <= halt_d;
            ifl_wr_q   <= ifl_wr_d;
            ifl_rd_q   <= ifl_rd_d;
            qcount_q   <= qcount_d;
            qhead_q    <= qhead_d;
            qtail_q    <= qtail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) ifl_pc_q[ifl_wr_q] <= fpc_q;
        if (!reset && enq)  queue_q[qtail_q]   <= enq_entry;
    end

    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset)
        !(bus.inst_sram_data_ok && inflight_q == '0));
endmodule
